shift_taps_multi: RTL and testbench

SHIFT_TAPS_MULTI -- requirements
Module: shift_taps_multi

---
 rtl/shift_taps_pkg.sv | 17 +
 rtl/shift_taps_multi_if.sv | 32 +++
 rtl/shift_taps_seg.sv | 36 +++
 rtl/shift_taps_multi.sv | 74 +++++++
 tb/tb_shift_taps_multi.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/shift_taps_pkg.sv
// Shared width helpers and tap/stage index mapping for the multi-tap shift register.
package shift_taps_pkg;

    function automatic int sel_width(int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    function automatic int fill_width(int depth);
        return (depth >= 1) ? $clog2(depth + 1) : 1;
    endfunction

    // Tap t sits on the last stage of its segment.
    function automatic int tap_stage(int t, int shift);
        return (t + 1) * shift - 1;
    endfunction

endpackage

// File: rtl/shift_taps_multi_if.sv
// Sample/tap bus between a producer and the multi-tap shift register.
interface shift_taps_multi_if
    import shift_taps_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1,
    parameter int TAPS  = 4
) ();
    localparam int N    = TAPS * SHIFT;
    localparam int SELW = sel_width(TAPS);
    localparam int FW   = fill_width(N);

    logic                    clear;
    logic                    ivalid;
    logic [WIDTH-1:0]        shiftin;
    logic [SELW-1:0]         tap_sel;
    logic                    ovalid;
    logic [WIDTH-1:0]        shiftout;
    logic [TAPS*WIDTH-1:0]   tapsout;
    logic [WIDTH-1:0]        selout;
    logic [FW-1:0]           fill;

    modport master (
        output clear, ivalid, shiftin, tap_sel,
        input  ovalid, shiftout, tapsout, selout, fill
    );

    modport slave (
        input  clear, ivalid, shiftin, tap_sel,
        output ovalid, shiftout, tapsout, selout, fill
    );
endinterface

// File: rtl/shift_taps_seg.sv
// One SHIFT-deep segment of the chain; dout is its last stage, i.e. one tap.
module shift_taps_seg #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_d [SHIFT];
    logic [WIDTH-1:0] stage_q [SHIFT];

    always_comb begin
        // NOTE: start from the held value so every path assigns stage_d and no latch is inferred.
        stage_d = stage_q;
        if (clr) begin
            stage_d = '{default: '0};
            if (en) stage_d[0] = din;
        end else if (en) begin
            stage_d[0] = din;
            for (int k = 1; k < SHIFT; k++) stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: the stages are reset (not left as uninitialised storage) so every tap reads 0 after reset.
        if (reset) stage_q <= '{default: '0};
        // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
        else       stage_q <= stage_d;
    end

    assign dout = stage_q[SHIFT-1];
endmodule

// File: rtl/shift_taps_multi.sv
// Chain of TAPS segments with fill tracking, window-valid strobe and a runtime tap mux.
module shift_taps_multi
    import shift_taps_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1,
    parameter int TAPS  = 4
) (
    input  logic               clock,
    input  logic               reset,
    shift_taps_multi_if.slave  bus
);
    localparam int N    = tap_stage(TAPS - 1, SHIFT) + 1;
    localparam int SELW = sel_width(TAPS);
    localparam int FW   = fill_width(N);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);

    logic [WIDTH-1:0] tap [TAPS];
    logic [FW-1:0]    fill_d, fill_q;
    logic             ovalid_d, ovalid_q;

    for (genvar t = 0; t < TAPS; t++) begin : g_seg
        logic [WIDTH-1:0] seg_in;
        // On clear only the head segment may load a sample; the rest flush to zero.
        if (t == 0) begin : g_head
            assign seg_in = bus.shiftin;
        end else begin : g_body
            assign seg_in = bus.clear ? '0 : tap[t-1];
        end

        shift_taps_seg #(
            .WIDTH (WIDTH),
            .SHIFT (SHIFT)
        ) u_seg (
            .clock (clock),
            .reset (reset),
            .en    (bus.ivalid),
            .clr   (bus.clear),
            .din   (seg_in),
            .dout  (tap[t])
        );

        assign bus.tapsout[t*WIDTH +: WIDTH] = tap[t];
    end

    assign bus.shiftout = tap[TAPS-1];

    always_comb begin
        bus.selout = '0;
        for (int t = 0; t < TAPS; t++) begin
            if (bus.tap_sel == SELW'(t)) bus.selout = tap[t];
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (bus.clear)                                fill_d = bus.ivalid ? FW'(1) : '0;
        else if (bus.ivalid && fill_q != FILL_FULL)   fill_d = fill_q + 1'b1;
        ovalid_d = bus.ivalid && (fill_d == FILL_FULL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fill_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            fill_q   <= fill_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign bus.fill   = fill_q;
    assign bus.ovalid = ovalid_q;
endmodule

// File: tb/tb_shift_taps_multi.sv
// Scoreboard bench: main DUT (32b, SHIFT=2, TAPS=4) plus TAPS=3 and N=1 variants on shared inputs.
module tb_shift_taps_multi;

    typedef struct {
        int           cyc;
        string        name;
        bit           chk_ctl;
        bit           ov;
        logic [3:0]   fill;
        bit           chk_dat;
        logic [127:0] taps;
        logic [31:0]  so;
        logic [31:0]  sel;
        bit           chk2;
        logic [31:0]  sel2;
        bit           chk3;
        bit           ov3;
        logic [31:0]  so3;
    } exp_t;

    localparam int SEL_MAIN [4] = '{7, 5, 3, 1};
    localparam int SEL_T3   [4] = '{7, 5, 3, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        iv  = 1'b0;
    logic [31:0] din = '0;
    logic [1:0]  sel = '0;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    shift_taps_multi_if #(.WIDTH(32), .SHIFT(2), .TAPS(4)) bus1 ();
    shift_taps_multi_if #(.WIDTH(32), .SHIFT(2), .TAPS(3)) bus2 ();
    shift_taps_multi_if #(.WIDTH(32), .SHIFT(1), .TAPS(1)) bus3 ();

    assign bus1.clear = clr;  assign bus1.ivalid = iv;  assign bus1.shiftin = din;  assign bus1.tap_sel = sel;
    assign bus2.clear = clr;  assign bus2.ivalid = iv;  assign bus2.shiftin = din;  assign bus2.tap_sel = sel;
    assign bus3.clear = clr;  assign bus3.ivalid = iv;  assign bus3.shiftin = din;  assign bus3.tap_sel = sel[0];

    shift_taps_multi #(.WIDTH(32), .SHIFT(2), .TAPS(4)) u_main (.clock(clk), .reset(rst), .bus(bus1));
    shift_taps_multi #(.WIDTH(32), .SHIFT(2), .TAPS(3)) u_t3   (.clock(clk), .reset(rst), .bus(bus2));
    shift_taps_multi #(.WIDTH(32), .SHIFT(1), .TAPS(1)) u_n1   (.clock(clk), .reset(rst), .bus(bus3));

    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [127:0] taps4(logic [31:0] t3, logic [31:0] t2, logic [31:0] t1, logic [31:0] t0);
        return {t3, t2, t1, t0};
    endfunction

    function automatic exp_t mk(string n, bit ov, int f);
        exp_t e;
        e.cyc = 0;       e.name = n;      e.chk_ctl = 1'b1; e.ov = ov;   e.fill = 4'(f);
        e.chk_dat = 0;   e.taps = '0;     e.so = '0;        e.sel = '0;
        e.chk2 = 0;      e.sel2 = '0;     e.chk3 = 0;       e.ov3 = 0;   e.so3 = '0;
        return e;
    endfunction

    function automatic exp_t dat(exp_t e, logic [127:0] taps, logic [31:0] so, logic [31:0] s);
        e.chk_dat = 1'b1; e.taps = taps; e.so = so; e.sel = s;
        return e;
    endfunction

    function automatic exp_t n1(exp_t e, bit ov, logic [31:0] so);
        e.chk3 = 1'b1; e.ov3 = ov; e.so3 = so;
        return e;
    endfunction

    task automatic drive(bit r, bit c, bit v, logic [31:0] d, logic [1:0] s);
        @(negedge clk);
        rst = r; clr = c; iv = v; din = d; sel = s;
    endtask

    task automatic push(exp_t e);
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Monitor: each rising edge presents a new output state; compare it against whatever expectation targets that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc < cyc) begin
                    check({e.name, ".stale_cycle"}, 128'(cyc), 128'(e.cyc));
                end else begin
                    if (e.chk_ctl) begin
                        check({e.name, ".ovalid"}, bus1.ovalid, e.ov);
                        check({e.name, ".fill"},   bus1.fill,   e.fill);
                    end
                    if (e.chk_dat) begin
                        check({e.name, ".tapsout"},  bus1.tapsout,  e.taps);
                        check({e.name, ".shiftout"}, bus1.shiftout, e.so);
                        check({e.name, ".selout"},   bus1.selout,   e.sel);
                    end
                    if (e.chk2) check({e.name, ".t3_selout"}, bus2.selout, e.sel2);
                    if (e.chk3) begin
                        check({e.name, ".n1_ovalid"},   bus3.ovalid,   e.ov3);
                        check({e.name, ".n1_shiftout"}, bus3.shiftout, e.so3);
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);

        // Reset state, then a continuous ramp 1..8.
        drive(1, 0, 0, 0, 0);
        push(n1(dat(mk("reset", 0, 0), '0, 0, 0), 0, 0));
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 1, 32'(k), 0);
            e = n1(mk($sformatf("ramp%0d", k), k == 8, k), 1, 32'(k));
            if (k == 4) e = dat(e, taps4(0, 0, 1, 3), 0, 3);
            if (k == 8) e = dat(e, taps4(1, 3, 5, 7), 1, 7);
            push(e);
        end

        // Idle tap_sel sweep on the full window; TAPS=3 variant returns 0 for sel=3.
        for (int s = 0; s < 4; s++) begin
            drive(0, 0, 0, 32'hDEAD, 2'(s));
            e = n1(dat(mk($sformatf("sweep%0d", s), 0, 8), taps4(1, 3, 5, 7), 1, 32'(SEL_MAIN[s])), 0, 8);
            e.chk2 = 1'b1; e.sel2 = 32'(SEL_T3[s]);
            push(e);
        end

        // Saturated fill keeps pulsing ovalid per sample.
        drive(0, 0, 1, 9, 0);
        push(n1(dat(mk("sat9", 1, 8), taps4(2, 4, 6, 8), 2, 8), 1, 9));

        // Clear with a sample, follow-up sample, then clear alone.
        drive(0, 1, 1, 32'hAA, 0);
        push(n1(dat(mk("clr_iv", 0, 1), '0, 0, 0), 1, 32'hAA));
        drive(0, 0, 1, 32'hBB, 0);
        push(n1(dat(mk("post_clr", 0, 2), taps4(0, 0, 0, 32'hAA), 0, 32'hAA), 1, 32'hBB));
        drive(0, 1, 0, 32'h55, 0);
        push(n1(dat(mk("clr_only", 0, 0), '0, 0, 0), 0, 0));

        // Same ramp with ivalid alternating; idle cycles hold everything.
        drive(1, 0, 0, 0, 0);
        push(n1(dat(mk("reset2", 0, 0), '0, 0, 0), 0, 0));
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 1, 32'(k), 0);
            e = n1(mk($sformatf("tog_on%0d", k), k == 8, k), 1, 32'(k));
            if (k == 4) e = dat(e, taps4(0, 0, 1, 3), 0, 3);
            if (k == 8) e = dat(e, taps4(1, 3, 5, 7), 1, 7);
            push(e);
            drive(0, 0, 0, 32'hDEAD, 0);
            e = n1(mk($sformatf("tog_off%0d", k), 0, k), 0, 32'(k));
            if (k == 4) e = dat(e, taps4(0, 0, 1, 3), 0, 3);
            if (k == 8) e = dat(e, taps4(1, 3, 5, 7), 1, 7);
            push(e);
        end

        // Reset mid-fill (asserted together with clear and ivalid), then a full refill.
        drive(1, 0, 0, 0, 0);
        push(mk("reset3", 0, 0));
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 1, 32'(k), 0);
            push(mk($sformatf("part%0d", k), 0, k));
        end
        drive(1, 1, 1, 32'h99, 0);
        push(n1(dat(mk("reset_mid", 0, 0), '0, 0, 0), 0, 0));
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 1, 32'h10 + 32'(k), 0);
            e = mk($sformatf("refill%0d", k + 1), k == 7, k + 1);
            if (k == 0) e = dat(e, '0, 0, 0);
            if (k == 7) e = dat(e, taps4(32'h10, 32'h12, 32'h14, 32'h16), 32'h10, 32'h16);
            push(e);
        end

        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
